// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch/decode boundary: widths, HALT encoding,
// instruction field positions and the run-control state encoding.
package isa_pkg;

    localparam int IW = 9;
    localparam int AW = 10;

    localparam logic [IW-1:0] HALT_WORD = 9'h1FF;

    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int FA_HI = 5;
    localparam int FA_LO = 3;
    localparam int FB_HI = 2;
    localparam int FB_LO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_state_t;

endpackage

// File: rtl/fetch_decode_reg.sv
// Fetch/decode pipeline register with stall/flush, field split, run-control FSM
// (IDLE/RUN/DONE) and a saturating count of retired fetches.
module fetch_decode_reg
    import isa_pkg::*;
#(
    parameter int              IW        = isa_pkg::IW,
    parameter int              AW        = isa_pkg::AW,
    parameter int              CW        = 16,
    parameter logic [IW-1:0]   HALT_WORD = isa_pkg::HALT_WORD
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [IW-1:0] InstIn,
    input  logic [AW-1:0] PcIn,
    input  logic          Stall,
    input  logic          Flush,
    output logic [IW-1:0] InstQ,
    output logic [AW-1:0] PcQ,
    output logic          Valid,
    output logic [2:0]    Opcode,
    output logic [2:0]    FieldA,
    output logic [2:0]    FieldB,
    output logic          Done,
    output logic [CW-1:0] InstCount,
    output run_state_t    StateDbg
);

    run_state_t    state_q, state_d;
    logic [IW-1:0] inst_q, inst_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] count_inc;

    assign count_inc = (count_q == {CW{1'b1}}) ? count_q : count_q + CW'(1);

    // In RUN each edge is one of: restart, bubble (Flush beats Stall),
    // hold (Stall), or capture. Valid marks InstQ as a real instruction.
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (Start) begin
                    state_d = RUN;
                    count_d = '0;
                end
            end
            RUN: begin
                if (Start) begin
                    valid_d = 1'b0;
                    inst_d  = '0;
                    count_d = '0;
                end else if (Flush) begin
                    valid_d = 1'b0;
                    inst_d  = '0;
                    pc_d    = PcIn;
                end else if (!Stall) begin
                    inst_d  = InstIn;
                    pc_d    = PcIn;
                    valid_d = 1'b1;
                    count_d = count_inc;
                    if (InstIn == HALT_WORD) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                valid_d = 1'b0;
                if (Start) begin
                    state_d = RUN;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            inst_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign InstQ     = inst_q;
    assign PcQ       = pc_q;
    assign Valid     = valid_q;
    assign Opcode    = inst_q[OP_HI:OP_LO];
    assign FieldA    = inst_q[FA_HI:FA_LO];
    assign FieldB    = inst_q[FB_HI:FB_LO];
    assign Done      = (state_q == DONE);
    assign InstCount = count_q;
    assign StateDbg  = state_q;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Directed bench for fetch_decode_reg: reset, capture/decode, stall/flush
// priority, HALT handling, restart and counter saturation (CW=4 instance).
module tb_fetch_decode_reg;
    import isa_pkg::*;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic [8:0]    InstIn;
    logic [9:0]    PcIn;
    logic          Stall;
    logic          Flush;

    logic [8:0]    inst_q, s_inst_q;
    logic [9:0]    pc_q, s_pc_q;
    logic          valid, s_valid;
    logic [2:0]    opcode, field_a, field_b;
    logic [2:0]    s_opcode, s_field_a, s_field_b;
    logic          done, s_done;
    logic [15:0]   inst_count;
    logic [3:0]    s_inst_count;
    run_state_t    state_dbg, s_state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    fetch_decode_reg dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .InstIn(InstIn), .PcIn(PcIn),
        .Stall(Stall), .Flush(Flush), .InstQ(inst_q), .PcQ(pc_q), .Valid(valid),
        .Opcode(opcode), .FieldA(field_a), .FieldB(field_b), .Done(done),
        .InstCount(inst_count), .StateDbg(state_dbg)
    );

    fetch_decode_reg #(.CW(4)) dut_sat (
        .Clk(Clk), .Reset(Reset), .Start(Start), .InstIn(InstIn), .PcIn(PcIn),
        .Stall(Stall), .Flush(Flush), .InstQ(s_inst_q), .PcQ(s_pc_q), .Valid(s_valid),
        .Opcode(s_opcode), .FieldA(s_field_a), .FieldB(s_field_b), .Done(s_done),
        .InstCount(s_inst_count), .StateDbg(s_state_dbg)
    );

    // clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one edge and sample 1 time unit after it
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [8:0] inst, input logic [9:0] pc,
                         input logic stl, input logic fl);
        Start  = st;
        InstIn = inst;
        PcIn   = pc;
        Stall  = stl;
        Flush  = fl;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_inst"},  32'(inst_q), 32'h0);
        check({tag, "_pc"},    32'(pc_q), 32'h0);
        check({tag, "_valid"}, 32'(valid), 32'h0);
        check({tag, "_done"},  32'(done), 32'h0);
        check({tag, "_cnt"},   32'(inst_count), 32'h0);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    initial begin
        drive(1'b0, 9'h0, 10'h0, 1'b0, 1'b0);
        Reset = 1'b1;
        #2 Reset = 1'b0;
        #2;
        check_all_zero("por");
        tick();
        tick();
        Reset = 1'b1;
        tick();
        check("release_state", 32'(state_dbg), 32'(IDLE));
        check("release_valid", 32'(valid), 32'h0);

        // start, then one capture
        drive(1'b1, 9'h0, 10'h0, 1'b0, 1'b0);
        tick();
        check("start_state", 32'(state_dbg), 32'(RUN));
        check("start_valid", 32'(valid), 32'h0);
        check("start_cnt", 32'(inst_count), 32'h0);
        drive(1'b0, 9'b001_011_010, 10'd100, 1'b0, 1'b0);
        tick();
        check("cap_inst", 32'(inst_q), 32'h05A);
        check("cap_op", 32'(opcode), 32'd1);
        check("cap_fa", 32'(field_a), 32'd3);
        check("cap_fb", 32'(field_b), 32'd2);
        check("cap_pc", 32'(pc_q), 32'd100);
        check("cap_valid", 32'(valid), 32'h1);
        check("cap_cnt", 32'(inst_count), 32'd1);

        // stall holds everything while inputs change
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 9'(9'h123 + i * 7), 10'(500 + i), 1'b1, 1'b0);
            tick();
            check("stall_inst", 32'(inst_q), 32'h05A);
            check("stall_pc", 32'(pc_q), 32'd100);
            check("stall_valid", 32'(valid), 32'h1);
            check("stall_cnt", 32'(inst_count), 32'd1);
        end

        // flush beats stall
        drive(1'b0, 9'h0C3, 10'd200, 1'b1, 1'b1);
        tick();
        check("sf_valid", 32'(valid), 32'h0);
        check("sf_inst", 32'(inst_q), 32'h0);
        check("sf_op", 32'({opcode, field_a, field_b}), 32'h0);
        check("sf_pc", 32'(pc_q), 32'd200);
        check("sf_cnt", 32'(inst_count), 32'd1);

        // flushed HALT is discarded
        drive(1'b0, 9'h1FF, 10'd201, 1'b0, 1'b1);
        tick();
        check("fh_state", 32'(state_dbg), 32'(RUN));
        check("fh_done", 32'(done), 32'h0);
        check("fh_valid", 32'(valid), 32'h0);
        check("fh_cnt", 32'(inst_count), 32'd1);

        drive(1'b0, 9'h0B4, 10'd300, 1'b0, 1'b0);
        tick();
        check("cap2_inst", 32'(inst_q), 32'h0B4);
        check("cap2_cnt", 32'(inst_count), 32'd2);

        // asynchronous reset mid-run
        Reset = 1'b0;
        #1;
        check_all_zero("arst");
        Reset = 1'b1;
        drive(1'b0, 9'h077, 10'd9, 1'b0, 1'b0);
        tick();
        check("arel_state", 32'(state_dbg), 32'(IDLE));
        check("arel_inst", 32'(inst_q), 32'h0);

        // run to HALT
        drive(1'b1, 9'h0, 10'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 9'h091, 10'd10, 1'b0, 1'b0);
        tick();
        check("h1_inst", 32'(inst_q), 32'h091);
        drive(1'b0, 9'h1FF, 10'd11, 1'b0, 1'b0);
        tick();
        check("halt_inst", 32'(inst_q), 32'h1FF);
        check("halt_valid", 32'(valid), 32'h1);
        check("halt_done", 32'(done), 32'h1);
        check("halt_cnt", 32'(inst_count), 32'd2);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 9'(i * 13 + 2), 10'(700 + i), 1'(i % 2), 1'(i % 3 == 0));
            tick();
            check("dn_inst", 32'(inst_q), 32'h1FF);
            check("dn_pc", 32'(pc_q), 32'd11);
            check("dn_valid", 32'(valid), 32'h0);
            check("dn_done", 32'(done), 32'h1);
            check("dn_cnt", 32'(inst_count), 32'd2);
        end

        // restart from DONE
        drive(1'b1, 9'h0, 10'd0, 1'b0, 1'b0);
        tick();
        check("rs_state", 32'(state_dbg), 32'(RUN));
        check("rs_done", 32'(done), 32'h0);
        check("rs_valid", 32'(valid), 32'h0);
        check("rs_cnt", 32'(inst_count), 32'h0);
        check("rs_scnt", 32'(s_inst_count), 32'h0);

        // saturation on the CW=4 instance
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 9'(k), 10'(k), 1'b0, 1'b0);
            tick();
            check("sat_cnt", 32'(s_inst_count), (k > 15) ? 32'd15 : 32'(k));
            check("wide_cnt", 32'(inst_count), 32'(k));
        end
        check("sat_state", 32'(s_state_dbg), 32'(RUN));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
